// File: rtl/nand_logic_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : nand_logic_sequencer_if
// Description : Request/response bundle between a requester and the NAND
//               logic sequencer.
//               Requester side: start, op, a, b (driven by master)
//               Sequencer side: busy, done, err, result (driven by slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface nand_logic_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;   // request, sampled only while idle
    logic [2:0]       op;      // function select, latched with start
    logic [WIDTH-1:0] a;       // operand A, latched with start
    logic [WIDTH-1:0] b;       // operand B, latched with start
    logic             busy;    // high while sequencing
    logic             done;    // one-cycle completion pulse
    logic             err;     // illegal op flag, valid from done
    logic [WIDTH-1:0] result;  // result, stable from done to next start

    modport master (
        output start,
        output op,
        output a,
        output b,
        input  busy,
        input  done,
        input  err,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  a,
        input  b,
        output busy,
        output done,
        output err,
        output result
    );
endinterface
`default_nettype wire

// File: rtl/nand_logic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nand_logic_sequencer
// Description : Serial bitwise logic unit built around a single 2-input NAND
//               cell. An FSM walks each operand bit through the NAND micro-op
//               sequence that realises the selected function, one NAND
//               evaluation per clock.
//               Ports:
//                 clk    - rising-edge clock
//                 rst_n  - asynchronous active-low reset
//                 bus    - slave side of nand_logic_sequencer_if
//                          (start/op/a/b in, busy/done/err/result out)
//               Functions (op): 0 NAND, 1 AND, 2 NOT A, 3 OR, 4 NOR,
//                               5 XOR, 6 XNOR, 7 illegal (err with done)
// Revision    : 1.0 - initial release
// ============================================================================
module nand_logic_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    nand_logic_sequencer_if.slave      bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_BIT = c_IDX_W'(WIDTH - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    // NAND operand sources
    localparam logic [2:0] c_SRC_A = 3'd0;
    localparam logic [2:0] c_SRC_B = 3'd1;
    localparam logic [2:0] c_SRC_T = 3'd2;
    localparam logic [2:0] c_SRC_U = 3'd3;
    localparam logic [2:0] c_SRC_V = 3'd4;

    // NAND destination: a temporary, or the result bit (final step of a bit)
    localparam logic [1:0] c_DST_T = 2'd0;
    localparam logic [1:0] c_DST_U = 2'd1;
    localparam logic [1:0] c_DST_V = 2'd2;
    localparam logic [1:0] c_DST_R = 2'd3;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [c_IDX_W-1:0] r_idx;
    logic [2:0]         r_step;
    logic               r_t;
    logic               r_u;
    logic               r_v;
    logic [WIDTH-1:0]   r_result;
    logic               r_err;
    logic               r_done;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [0:0] w_state_nxt;
    logic       w_run;
    logic       w_accept;
    logic [2:0] w_src_x;
    logic [2:0] w_src_y;
    logic [1:0] w_dst;
    logic [2:0] w_last_step_idx;
    logic       w_illegal;
    logic       w_a_bit;
    logic       w_b_bit;
    logic       w_x;
    logic       w_y;
    logic       w_nand;
    logic       w_step_last;
    logic       w_bit_last;
    logic       w_done_nxt;

    assign w_run    = (r_state == c_RUN);
    assign w_accept = (r_state == c_IDLE) && bus.start;
    assign w_a_bit  = r_a[r_idx];
    assign w_b_bit  = r_b[r_idx];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = c_RUN;
                end
            end
            default: begin
                // Leave RUN on the final micro-op of the top bit, or at once
                // for an illegal op.
                if (w_done_nxt) begin
                    w_state_nxt = c_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / micro-op decode
    // Each (op, step) pair selects the two NAND inputs and where the NAND
    // output lands. Temporaries are registers, so a step reads the values
    // written by earlier steps of the same bit.
    // ------------------------------------------------------------------------
    always_comb begin
        w_src_x         = c_SRC_A;
        w_src_y         = c_SRC_B;
        w_dst           = c_DST_R;
        w_last_step_idx = 3'd0;
        w_illegal       = 1'b0;

        case (r_op)
            3'd0: begin
                // NAND: r = nand(a,b)
            end
            3'd1: begin
                // AND: t = nand(a,b); r = nand(t,t)
                w_last_step_idx = 3'd1;
                if (r_step == 3'd0) begin
                    w_dst = c_DST_T;
                end else begin
                    w_src_x = c_SRC_T;
                    w_src_y = c_SRC_T;
                end
            end
            3'd2: begin
                // NOT A: r = nand(a,a)
                w_src_y = c_SRC_A;
            end
            3'd3: begin
                // OR: t = nand(a,a); u = nand(b,b); r = nand(t,u)
                w_last_step_idx = 3'd2;
                case (r_step)
                    3'd0:    begin w_src_x = c_SRC_A; w_src_y = c_SRC_A; w_dst = c_DST_T; end
                    3'd1:    begin w_src_x = c_SRC_B; w_src_y = c_SRC_B; w_dst = c_DST_U; end
                    default: begin w_src_x = c_SRC_T; w_src_y = c_SRC_U; end
                endcase
            end
            3'd4: begin
                // NOR: OR into t, then r = nand(t,t)
                w_last_step_idx = 3'd3;
                case (r_step)
                    3'd0:    begin w_src_x = c_SRC_A; w_src_y = c_SRC_A; w_dst = c_DST_T; end
                    3'd1:    begin w_src_x = c_SRC_B; w_src_y = c_SRC_B; w_dst = c_DST_U; end
                    3'd2:    begin w_src_x = c_SRC_T; w_src_y = c_SRC_U; w_dst = c_DST_T; end
                    default: begin w_src_x = c_SRC_T; w_src_y = c_SRC_T; end
                endcase
            end
            3'd5: begin
                // XOR: t = nand(a,b); u = nand(a,t); v = nand(b,t); r = nand(u,v)
                w_last_step_idx = 3'd3;
                case (r_step)
                    3'd0:    begin w_src_x = c_SRC_A; w_src_y = c_SRC_B; w_dst = c_DST_T; end
                    3'd1:    begin w_src_x = c_SRC_A; w_src_y = c_SRC_T; w_dst = c_DST_U; end
                    3'd2:    begin w_src_x = c_SRC_B; w_src_y = c_SRC_T; w_dst = c_DST_V; end
                    default: begin w_src_x = c_SRC_U; w_src_y = c_SRC_V; end
                endcase
            end
            3'd6: begin
                // XNOR: XOR into t, then r = nand(t,t)
                w_last_step_idx = 3'd4;
                case (r_step)
                    3'd0:    begin w_src_x = c_SRC_A; w_src_y = c_SRC_B; w_dst = c_DST_T; end
                    3'd1:    begin w_src_x = c_SRC_A; w_src_y = c_SRC_T; w_dst = c_DST_U; end
                    3'd2:    begin w_src_x = c_SRC_B; w_src_y = c_SRC_T; w_dst = c_DST_V; end
                    3'd3:    begin w_src_x = c_SRC_U; w_src_y = c_SRC_V; w_dst = c_DST_T; end
                    default: begin w_src_x = c_SRC_T; w_src_y = c_SRC_T; end
                endcase
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase

        case (w_src_x)
            c_SRC_A: w_x = w_a_bit;
            c_SRC_B: w_x = w_b_bit;
            c_SRC_T: w_x = r_t;
            c_SRC_U: w_x = r_u;
            default: w_x = r_v;
        endcase

        case (w_src_y)
            c_SRC_A: w_y = w_a_bit;
            c_SRC_B: w_y = w_b_bit;
            c_SRC_T: w_y = r_t;
            c_SRC_U: w_y = r_u;
            default: w_y = r_v;
        endcase

        // The one shared NAND cell
        w_nand = ~(w_x & w_y);

        w_step_last = (r_step == w_last_step_idx);
        w_bit_last  = (r_idx == c_LAST_BIT);
        w_done_nxt  = w_run && (w_illegal || (w_step_last && w_bit_last));
    end

    // ------------------------------------------------------------------------
    // Datapath: operand latch, temporaries, counters, outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 3'd0;
            r_idx    <= '0;
            r_step   <= 3'd0;
            r_t      <= 1'b0;
            r_u      <= 1'b0;
            r_v      <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_done_nxt;

            if (w_accept) begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_op     <= bus.op;
                r_idx    <= '0;
                r_step   <= 3'd0;
                r_t      <= 1'b0;
                r_u      <= 1'b0;
                r_v      <= 1'b0;
                r_result <= '0;
                r_err    <= 1'b0;
            end else if (w_run) begin
                if (w_illegal) begin
                    // No NAND work; result stays cleared from accept.
                    r_err <= 1'b1;
                end else begin
                    case (w_dst)
                        c_DST_T: r_t <= w_nand;
                        c_DST_U: r_u <= w_nand;
                        c_DST_V: r_v <= w_nand;
                        default: r_result[r_idx] <= w_nand;
                    endcase

                    if (w_step_last) begin
                        r_step <= 3'd0;
                        // Hold on the top bit so the index never wraps.
                        if (!w_bit_last) begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.busy   = w_run;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;

endmodule
`default_nettype wire
